// File: rtl/shared_mult_arbiter_if.sv
// Client-side bundle of the shared multiplier front end: requests, operands,
// grants and tagged product returns.
interface shared_mult_arbiter_if #(
    parameter int unsigned N_CLIENTS = 4
);
    logic [N_CLIENTS-1:0]    req;
    logic [N_CLIENTS*32-1:0] req_a;
    logic [N_CLIENTS*32-1:0] req_b;
    logic [N_CLIENTS-1:0]    grant;
    logic [N_CLIENTS-1:0]    rsp_valid;
    logic [63:0]             rsp_p;

    modport master (
        output req, req_a, req_b,
        input  grant, rsp_valid, rsp_p
    );

    modport slave (
        input  req, req_a, req_b,
        output grant, rsp_valid, rsp_p
    );
endinterface

// File: rtl/shared_mult_arbiter.sv
// Round-robin front end for one shared pipelined 32x32 signed multiplier:
// issues one client operation per cycle and returns each product by client tag.
module shared_mult_arbiter #(
    parameter int unsigned N_CLIENTS = 4,
    parameter int unsigned LATENCY   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    shared_mult_arbiter_if.slave  cli,
    output logic [31:0]           m_a,
    output logic [31:0]           m_b,
    input  logic [63:0]           m_p,
    output logic                  busy
);
    localparam int unsigned TAG_W = $clog2(N_CLIENTS);
    localparam int unsigned SUM_W = TAG_W + 1;

    logic [TAG_W-1:0]     ptr_q, ptr_d;
    logic [SUM_W-1:0]     scan_sum;
    logic [SUM_W-1:0]     ptr_inc;
    logic [TAG_W-1:0]     scan_idx;
    logic                 gnt_vld;
    logic [TAG_W-1:0]     gnt_idx;
    logic [N_CLIENTS-1:0] grant_c;

    logic [LATENCY:0]     pv_q, pv_d;
    logic [TAG_W-1:0]     ptag_q [LATENCY+1];
    logic [TAG_W-1:0]     ptag_d [LATENCY+1];

    logic [31:0]          m_a_q, m_a_d, m_b_q, m_b_d;
    logic [N_CLIENTS-1:0] rsp_valid_q, rsp_valid_d;
    logic [63:0]          rsp_p_q, rsp_p_d;
    logic                 busy_q, busy_d;

    // Round-robin search starting at ptr, wrapping modulo N_CLIENTS.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int k = 0; k < int'(N_CLIENTS); k++) begin
            scan_sum = SUM_W'(ptr_q) + SUM_W'(k);
            if (scan_sum >= SUM_W'(N_CLIENTS)) begin
                scan_sum = scan_sum - SUM_W'(N_CLIENTS);
            end
            scan_idx = scan_sum[TAG_W-1:0];
            if (!gnt_vld && cli.req[scan_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan_idx;
            end
        end
        // Reset wins over any request in the same cycle.
        gnt_vld = gnt_vld && !rst;
        grant_c = '0;
        if (gnt_vld) begin
            grant_c[gnt_idx] = 1'b1;
        end
    end

    // Next-state for pointer, operands, tag pipe, response and busy.
    always_comb begin
        ptr_d   = ptr_q;
        ptr_inc = SUM_W'(gnt_idx) + SUM_W'(1);
        m_a_d   = m_a_q;
        m_b_d   = m_b_q;
        if (gnt_vld) begin
            ptr_d = (ptr_inc == SUM_W'(N_CLIENTS)) ? '0 : ptr_inc[TAG_W-1:0];
            for (int i = 0; i < int'(N_CLIENTS); i++) begin
                if (gnt_idx == TAG_W'(i)) begin
                    m_a_d = cli.req_a[32*i +: 32];
                    m_b_d = cli.req_b[32*i +: 32];
                end
            end
        end

        pv_d[0]   = gnt_vld;
        ptag_d[0] = gnt_idx;
        for (int i = 1; i <= int'(LATENCY); i++) begin
            pv_d[i]   = pv_q[i-1];
            ptag_d[i] = ptag_q[i-1];
        end

        rsp_valid_d = '0;
        rsp_p_d     = rsp_p_q;
        if (pv_q[LATENCY]) begin
            rsp_valid_d[ptag_q[LATENCY]] = 1'b1;
            rsp_p_d                      = m_p;
        end

        busy_d = (|pv_d) || (|rsp_valid_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            pv_q        <= '0;
            m_a_q       <= '0;
            m_b_q       <= '0;
            rsp_valid_q <= '0;
            rsp_p_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            pv_q        <= pv_d;
            m_a_q       <= m_a_d;
            m_b_q       <= m_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_p_q     <= rsp_p_d;
            busy_q      <= busy_d;
        end
    end

    // Tags are only meaningful alongside their valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i <= int'(LATENCY); i++) begin
            ptag_q[i] <= ptag_d[i];
        end
    end

    assign cli.grant     = grant_c;
    assign cli.rsp_valid = rsp_valid_q;
    assign cli.rsp_p     = rsp_p_q;
    assign m_a           = m_a_q;
    assign m_b           = m_b_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_shared_mult_arbiter.sv
// Bench for shared_mult_arbiter: directed cases with literal expectations plus
// random traffic checked every cycle against a queue-based scoreboard.
module tb_shared_mult_arbiter;
    localparam int unsigned N   = 4;
    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m_a, m_b;
    logic [63:0] m_p;
    logic        busy;

    logic [31:0] opa [N];
    logic [31:0] opb [N];

    shared_mult_arbiter_if #(.N_CLIENTS(N)) cif ();

    shared_mult_arbiter #(.N_CLIENTS(N), .LATENCY(LAT)) dut (
        .clk  (clk),
        .rst  (rst),
        .cli  (cif),
        .m_a  (m_a),
        .m_b  (m_b),
        .m_p  (m_p),
        .busy (busy)
    );

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign cif.req_a[32*gi +: 32] = opa[gi];
        assign cif.req_b[32*gi +: 32] = opb[gi];
    end

    // Stand-in for the shared multiplier: LAT-stage signed product pipe.
    logic [63:0] mp_pipe [LAT];
    always @(posedge clk) begin
        mp_pipe[0] <= 64'(longint'($signed(m_a)) * longint'($signed(m_b)));
        for (int i = 1; i < LAT; i++) mp_pipe[i] <= mp_pipe[i-1];
    end
    assign m_p = mp_pipe[LAT-1];

    typedef struct {
        int          issue;
        int          due;
        logic [1:0]  cli;
        logic [63:0] p;
    } item_t;

    item_t       sb [$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    bit          chk_en = 1'b0;
    logic [1:0]  m_ptr;
    logic [31:0] m_last_a, m_last_b;
    logic [63:0] m_rsp_p;
    int          wait_cnt [N];

    logic [N-1:0] s_grant, s_rv;
    logic [63:0]  s_rsp_p;
    logic [31:0]  s_ma, s_mb;
    logic         s_busy;
    logic [1:0]   ci;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h expected %0h", nm, cyc, got, exp);
        end
    endtask

    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        return 64'(longint'($signed(a)) * longint'($signed(b)));
    endfunction

    // Sample the cycle, compare against the model, then advance the model.
    task automatic model_cycle();
        bit           found;
        logic [1:0]   gi, idx;
        logic [N-1:0] eg, erv;
        logic         eb;
        cyc++;
        s_grant = cif.grant;
        s_rv    = cif.rsp_valid;
        s_rsp_p = cif.rsp_p;
        s_ma    = m_a;
        s_mb    = m_b;
        s_busy  = busy;
        if (!chk_en) return;

        found = 1'b0;
        gi    = '0;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                idx = 2'(m_ptr + 2'(k));
                if (!found && cif.req[idx]) begin
                    found = 1'b1;
                    gi    = idx;
                end
            end
        end
        eg = '0;
        if (found) eg[gi] = 1'b1;

        eb  = (sb.size() > 0) && (sb[0].issue < cyc);
        erv = '0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            erv[sb[0].cli] = 1'b1;
            m_rsp_p        = sb[0].p;
            void'(sb.pop_front());
        end

        chk("grant", s_grant, eg);
        chk("rsp_valid", s_rv, erv);
        chk("rsp_p", s_rsp_p, m_rsp_p);
        chk("m_a", s_ma, m_last_a);
        chk("m_b", s_mb, m_last_b);
        chk("busy", s_busy, eb);

        for (int i = 0; i < N; i++) begin
            if (rst || !cif.req[i] || eg[i]) begin
                wait_cnt[i] = 0;
            end else begin
                wait_cnt[i]++;
                chk("fairness_wait", 64'(wait_cnt[i] < N), 64'd1);
            end
        end

        if (rst) begin
            sb.delete();
            m_ptr    = '0;
            m_last_a = '0;
            m_last_b = '0;
            m_rsp_p  = '0;
        end else if (found) begin
            sb.push_back('{issue: cyc, due: cyc + LAT + 2, cli: gi,
                           p: smul(opa[gi], opb[gi])});
            m_last_a = opa[gi];
            m_last_b = opb[gi];
            m_ptr    = 2'(gi + 2'd1);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [1:0] i, input logic [31:0] a, input logic [31:0] b);
        cif.req[i] = 1'b1;
        opa[i]     = a;
        opb[i]     = b;
    endtask

    task automatic drop_granted();
        cif.req = cif.req & ~s_grant;
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst     = 1'b1;
        cif.req = '0;
        for (int i = 0; i < N; i++) begin
            opa[i]      = '0;
            opb[i]      = '0;
            wait_cnt[i] = 0;
        end
        m_ptr = '0; m_last_a = '0; m_last_b = '0; m_rsp_p = '0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        // Reset state.
        cycle();
        chk("rst_busy", s_busy, 0);
        chk("rst_rsp_valid", s_rv, 0);
        chk("rst_m_a", s_ma, 0);
        chk("rst_rsp_p", s_rsp_p, 0);
        rst = 1'b0;
        repeat (3) cycle();

        // Single request from client 2: 3 * -5.
        set_req(2'd2, 32'd3, 32'hFFFF_FFFB);
        cycle();
        chk("single_grant", s_grant, 4'b0100);
        drop_granted();
        cycle();
        chk("single_m_a", s_ma, 32'd3);
        chk("single_m_b", s_mb, 32'hFFFF_FFFB);
        cycle();
        cycle();
        cycle();
        chk("single_rsp_valid", s_rv, 4'b0100);
        chk("single_rsp_p", s_rsp_p, 64'hFFFF_FFFF_FFFF_FFF1);
        chk("single_busy_hi", s_busy, 1);
        cycle();
        chk("single_busy_lo", s_busy, 0);
        chk("single_rsp_off", s_rv, 0);

        // All four from reset; reset must suppress the grant in its own cycle.
        rst = 1'b1;
        for (int i = 0; i < N; i++) set_req(2'(i), 32'(i + 1), 32'd1000);
        cycle();
        chk("all_rst_grant", s_grant, 0);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (k < 4) begin
                chk("all_grant", s_grant, 64'(1) << k);
            end else begin
                chk("all_rsp_valid", s_rv, 64'(1) << (k - 4));
                chk("all_rsp_p", s_rsp_p, 64'((k - 3) * 1000));
            end
            drop_granted();
        end

        // Clients 1 and 3 continuously: strict alternation.
        set_req(2'd1, $urandom, $urandom);
        set_req(2'd3, $urandom, $urandom);
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("alt_grant", s_grant, (k % 2 == 0) ? 4'b0010 : 4'b1000);
            if (s_grant[1]) set_req(2'd1, $urandom, $urandom);
            else            set_req(2'd3, $urandom, $urandom);
        end
        cif.req = '0;
        repeat (6) cycle();

        // Extremes.
        set_req(2'd0, 32'h8000_0000, 32'h8000_0000);
        set_req(2'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
        cycle();
        chk("ext_grant0", s_grant, 4'b0001);
        drop_granted();
        cycle();
        chk("ext_grant1", s_grant, 4'b0010);
        drop_granted();
        cycle();
        cycle();
        cycle();
        chk("ext_rsp_valid0", s_rv, 4'b0001);
        chk("ext_rsp_p0", s_rsp_p, 64'h4000_0000_0000_0000);
        cycle();
        chk("ext_rsp_valid1", s_rv, 4'b0010);
        chk("ext_rsp_p1", s_rsp_p, 64'hFFFF_FFFF_8000_0001);
        repeat (3) cycle();

        // Reset while a product is in flight.
        set_req(2'd0, 32'd7, 32'd9);
        cycle();
        chk("mid_grant", s_grant, 4'b0001);
        drop_granted();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("mid_no_rsp", s_rv, 0);
            if (k == 0) chk("mid_busy", s_busy, 0);
        end
        for (int i = 0; i < N; i++) set_req(2'(i), $urandom, $urandom);
        cycle();
        chk("mid_post_grant", s_grant, 4'b0001);
        repeat (4) begin
            drop_granted();
            cycle();
        end
        cif.req = '0;
        repeat (6) cycle();

        // Random traffic with occasional reset.
        for (int n = 0; n < 10000; n++) begin
            rst = ($urandom_range(0, 499) == 0);
            for (int i = 0; i < N; i++) begin
                ci = 2'(i);
                if (!cif.req[ci] || s_grant[ci]) begin
                    if ($urandom_range(0, 3) != 0) set_req(ci, rnd_op(), rnd_op());
                    else                           cif.req[ci] = 1'b0;
                end
            end
            cycle();
        end
        rst     = 1'b0;
        cif.req = '0;
        repeat (8) cycle();
        chk("drain_empty", 64'(sb.size()), 0);
        chk("drain_busy", s_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
